// File: rtl/morse_shift_reg.sv
// Serial symbol emitter: loads a parallel pattern and shifts out LEN bits on
// SHIFT_EN strobes, pulsing DONE once the last bit has been presented on Q.
module morse_shift_reg #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter bit FILL_BIT   = 1'b0,
  localparam int LW        = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic [LW-1:0]    LEN,
  input  logic             SHIFT_EN,
  output logic             Q,
  output logic [WIDTH-1:0] PAR_Q,
  output logic             BUSY,
  output logic             DONE,
  output logic [LW-1:0]    REMAIN
);

  localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [LW-1:0]    remain_q, remain_d;
  logic             q_q, q_d;
  logic             done_q, done_d;

  // Saturate requested length to the register width; REMAIN never wraps.
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
    if (len > WIDTH_L) return WIDTH_L;
    return len;
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return {v[WIDTH-2:0], FILL_BIT};
    return {FILL_BIT, v[WIDTH-1:1]};
  endfunction

  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return v[WIDTH-1];
    return v[0];
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      remain_q <= '0;
      q_q      <= IDLE_LEVEL;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      remain_q <= remain_d;
      q_q      <= q_d;
      done_q   <= done_d;
    end
  end

  // LOAD wins over SHIFT_EN; a load mid-emission restarts without a DONE.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    remain_d = remain_q;
    q_d      = q_q;
    done_d   = 1'b0;
    if (LOAD) begin
      sreg_d   = D;
      remain_d = clamp_len(LEN);
      if (remain_d != '0) begin
        state_d = SHIFT;
        q_d     = out_bit(D);
      end else begin
        state_d = IDLE;
        q_d     = IDLE_LEVEL;
        done_d  = 1'b1;
      end
    end else if (state_q == SHIFT && SHIFT_EN) begin
      sreg_d   = shift_once(sreg_q);
      remain_d = remain_q - ONE_L;
      if (remain_q == ONE_L) begin
        state_d = IDLE;
        q_d     = IDLE_LEVEL;
        done_d  = 1'b1;
      end else begin
        q_d = out_bit(sreg_d);
      end
    end
  end

  assign Q      = q_q;
  assign PAR_Q  = sreg_q;
  assign BUSY   = (state_q == SHIFT);
  assign DONE   = done_q;
  assign REMAIN = remain_q;

endmodule

// File: tb/tb_morse_shift_reg.sv
// Directed bench for morse_shift_reg: MSB-first default instance plus an
// LSB-first instance sharing the same stimulus.
module tb_morse_shift_reg;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       LOAD;
  logic [7:0] D;
  logic [3:0] LEN;
  logic       SHIFT_EN;

  logic       Q, BUSY, DONE;
  logic [7:0] PAR_Q;
  logic [3:0] REMAIN;
  logic       Q_L, BUSY_L, DONE_L;
  logic [7:0] PAR_Q_L;
  logic [3:0] REMAIN_L;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  morse_shift_reg dut (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .D(D), .LEN(LEN), .SHIFT_EN(SHIFT_EN),
    .Q(Q), .PAR_Q(PAR_Q), .BUSY(BUSY), .DONE(DONE), .REMAIN(REMAIN)
  );

  morse_shift_reg #(.MSB_FIRST(1'b0)) dut_lsb (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .D(D), .LEN(LEN), .SHIFT_EN(SHIFT_EN),
    .Q(Q_L), .PAR_Q(PAR_Q_L), .BUSY(BUSY_L), .DONE(DONE_L), .REMAIN(REMAIN_L)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; LOAD = 1'b1; D = 8'hFF; LEN = 4'd3; SHIFT_EN = 1'b1;
    tick();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    checks++; if (REMAIN !== 4'd0) begin errors++; $display("FAIL reset_remain got %0d exp 0", REMAIN); end
    checks++; if (PAR_Q !== 8'h00) begin errors++; $display("FAIL reset_parq got %h exp 00", PAR_Q); end
    checks++; if (Q !== 1'b0) begin errors++; $display("FAIL reset_q got %b exp 0", Q); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", DONE); end
    checks++; if (BUSY_L !== 1'b0 || PAR_Q_L !== 8'h00) begin
      errors++; $display("FAIL reset_lsb got busy %b parq %h exp 0 00", BUSY_L, PAR_Q_L);
    end
    RST_N = 1'b1; LOAD = 1'b0; SHIFT_EN = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] exp_q;
    int dones;
    exp_q = 4'b1011;
    dones = 0;
    LOAD = 1'b1; D = 8'b1011_0000; LEN = 4'd4; SHIFT_EN = 1'b1;
    tick();
    LOAD = 1'b0;
    checks++; if (PAR_Q !== 8'hB0) begin errors++; $display("FAIL basic_load_parq got %h exp b0", PAR_Q); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (Q !== exp_q[3-i]) begin errors++; $display("FAIL basic_q[%0d] got %b exp %b", i, Q, exp_q[3-i]); end
      checks++; if (REMAIN !== 4'(4 - i)) begin errors++; $display("FAIL basic_remain[%0d] got %0d exp %0d", i, REMAIN, 4 - i); end
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d] got %b exp 1", i, BUSY); end
      if (DONE) dones++;
      tick();
    end
    if (DONE) dones++;
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", DONE); end
    checks++; if (BUSY !== 1'b0 || Q !== 1'b0) begin errors++; $display("FAIL basic_idle got busy %b q %b exp 0 0", BUSY, Q); end
    checks++; if (PAR_Q !== 8'h00 || REMAIN !== 4'd0) begin
      errors++; $display("FAIL basic_end got parq %h remain %0d exp 00 0", PAR_Q, REMAIN);
    end
    SHIFT_EN = 1'b0;
    tick();
    if (DONE) dones++;
    checks++; if (dones !== 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", dones); end
  endtask

  task automatic test_lsb();
    logic [3:0] exp_q;
    exp_q = 4'b1011;
    LOAD = 1'b1; D = 8'h0D; LEN = 4'd4; SHIFT_EN = 1'b1;
    tick();
    LOAD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (Q_L !== exp_q[3-i]) begin errors++; $display("FAIL lsb_q[%0d] got %b exp %b", i, Q_L, exp_q[3-i]); end
      tick();
    end
    checks++; if (DONE_L !== 1'b1 || BUSY_L !== 1'b0) begin
      errors++; $display("FAIL lsb_done got done %b busy %b exp 1 0", DONE_L, BUSY_L);
    end
    checks++; if (PAR_Q_L !== 8'h00) begin errors++; $display("FAIL lsb_parq got %h exp 00", PAR_Q_L); end
    SHIFT_EN = 1'b0;
    tick();
  endtask

  task automatic test_restart();
    int dones;
    dones = 0;
    LOAD = 1'b1; D = 8'b1010_1000; LEN = 4'd5; SHIFT_EN = 1'b1;
    tick();
    LOAD = 1'b0;
    checks++; if (Q !== 1'b1 || REMAIN !== 4'd5) begin errors++; $display("FAIL restart_first got q %b remain %0d exp 1 5", Q, REMAIN); end
    tick();
    checks++; if (Q !== 1'b0 || REMAIN !== 4'd4) begin errors++; $display("FAIL restart_shift1 got q %b remain %0d exp 0 4", Q, REMAIN); end
    LOAD = 1'b1; D = 8'hFF; LEN = 4'd2;
    tick();
    LOAD = 1'b0;
    if (DONE) dones++;
    checks++; if (Q !== 1'b1 || REMAIN !== 4'd2 || PAR_Q !== 8'hFF) begin
      errors++; $display("FAIL restart_reload got q %b remain %0d parq %h exp 1 2 ff", Q, REMAIN, PAR_Q);
    end
    tick();
    if (DONE) dones++;
    checks++; if (Q !== 1'b1 || REMAIN !== 4'd1) begin errors++; $display("FAIL restart_bit2 got q %b remain %0d exp 1 1", Q, REMAIN); end
    tick();
    if (DONE) dones++;
    checks++; if (BUSY !== 1'b0 || Q !== 1'b0 || PAR_Q !== 8'hFC) begin
      errors++; $display("FAIL restart_end got busy %b q %b parq %h exp 0 0 fc", BUSY, Q, PAR_Q);
    end
    SHIFT_EN = 1'b0;
    tick();
    if (DONE) dones++;
    checks++; if (dones !== 1) begin errors++; $display("FAIL restart_done_count got %0d exp 1", dones); end
  endtask

  task automatic test_len0_clamp();
    logic [7:0] pat;
    pat = 8'hCA;
    LOAD = 1'b1; D = 8'h55; LEN = 4'd0; SHIFT_EN = 1'b0;
    tick();
    LOAD = 1'b0;
    checks++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL len0_done got done %b busy %b exp 1 0", DONE, BUSY); end
    checks++; if (REMAIN !== 4'd0 || Q !== 1'b0 || PAR_Q !== 8'h55) begin
      errors++; $display("FAIL len0_state got remain %0d q %b parq %h exp 0 0 55", REMAIN, Q, PAR_Q);
    end
    tick();
    checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL len0_after got done %b busy %b exp 0 0", DONE, BUSY); end
    LOAD = 1'b1; D = pat; LEN = 4'd12; SHIFT_EN = 1'b1;
    tick();
    LOAD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (Q !== pat[7-i] || REMAIN !== 4'(8 - i) || BUSY !== 1'b1) begin
        errors++; $display("FAIL clamp_bit[%0d] got q %b remain %0d busy %b exp %b %0d 1", i, Q, REMAIN, BUSY, pat[7-i], 8 - i);
      end
      tick();
    end
    checks++; if (DONE !== 1'b1 || BUSY !== 1'b0 || PAR_Q !== 8'h00) begin
      errors++; $display("FAIL clamp_end got done %b busy %b parq %h exp 1 0 00", DONE, BUSY, PAR_Q);
    end
    SHIFT_EN = 1'b0;
    tick();
  endtask

  task automatic test_gapped_reset();
    logic [7:0] pat;
    pat = 8'h96;
    LOAD = 1'b1; D = pat; LEN = 4'd6; SHIFT_EN = 1'b0;
    tick();
    LOAD = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      SHIFT_EN = 1'b0;
      for (int h = 0; h < 2; h++) begin
        tick();
        checks++; if (Q !== pat[8-k] || REMAIN !== 4'(7 - k)) begin
          errors++; $display("FAIL gap_hold[%0d] got q %b remain %0d exp %b %0d", k, Q, REMAIN, pat[8-k], 7 - k);
        end
      end
      SHIFT_EN = 1'b1;
      tick();
      checks++; if (Q !== pat[7-k] || REMAIN !== 4'(6 - k)) begin
        errors++; $display("FAIL gap_step[%0d] got q %b remain %0d exp %b %0d", k, Q, REMAIN, pat[7-k], 6 - k);
      end
    end
    SHIFT_EN = 1'b0;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    checks++; if (BUSY !== 1'b0 || REMAIN !== 4'd0 || PAR_Q !== 8'h00 || Q !== 1'b0 || DONE !== 1'b0) begin
      errors++; $display("FAIL midreset got busy %b remain %0d parq %h q %b done %b exp 0 0 00 0 0", BUSY, REMAIN, PAR_Q, Q, DONE);
    end
    SHIFT_EN = 1'b1;
    tick();
    checks++; if (DONE !== 1'b0 || BUSY !== 1'b0 || PAR_Q !== 8'h00) begin
      errors++; $display("FAIL idle_shift got done %b busy %b parq %h exp 0 0 00", DONE, BUSY, PAR_Q);
    end
    SHIFT_EN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b0; LOAD = 1'b0; D = '0; LEN = '0; SHIFT_EN = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_lsb();
    test_restart();
    test_len0_clamp();
    test_gapped_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_shift_reg.md
MORSE_SHIFT_REG -- requirements
Module: morse_shift_reg

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8, giving the shift register width in bits; legal range 2..32.
REQ-002 The block SHALL have the parameter MSB_FIRST, default 1; 1 = shift out from bit WIDTH-1, 0 = shift out from bit 0.
REQ-003 The block SHALL have the parameter IDLE_LEVEL, default 0, giving the level of Q while not busy.
REQ-004 The block SHALL have the parameter FILL_BIT, default 0, giving the value shifted into vacated positions.
REQ-005 LW SHALL equal clog2(WIDTH+1) and is a derived localparam, not user-settable.
REQ-006 The block SHALL have the port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have the port RST_N, input, 1 bit: a synchronous, active-low reset.
REQ-008 The block SHALL have the port LOAD, input, 1 bit: a load request for D and LEN.
REQ-009 The block SHALL have the port D, input, WIDTH bits: the parallel symbol pattern.
REQ-010 The block SHALL have the port LEN, input, LW bits: the number of bits to emit.
REQ-011 The block SHALL have the port SHIFT_EN, input, 1 bit: the bit-period strobe that advances one bit.
REQ-012 The block SHALL have the port Q, output, 1 bit: the registered serial output.
REQ-013 The block SHALL have the port PAR_Q, output, WIDTH bits: the current shift register contents.
REQ-014 The block SHALL have the port BUSY, output, 1 bit: high while bits remain to emit.
REQ-015 The block SHALL have the port DONE, output, 1 bit: a one-cycle pulse when emission completes.
REQ-016 The block SHALL have the port REMAIN, output, LW bits: the number of bits still to emit, including the bit on Q.

Function
REQ-017 The block SHALL have two states: IDLE (BUSY=0) and SHIFT (BUSY=1).
REQ-018 LOAD=1 in any state SHALL, on the next edge, capture D into the shift register and set REMAIN to min(LEN, WIDTH).
  - A LOAD during SHIFT aborts the current emission and restarts.
  - No DONE pulse is generated for the aborted emission.
REQ-019 A LOAD with effective LEN>0 SHALL enter SHIFT, and Q SHALL present the first bit in the cycle after the loading edge.
  - The first bit is D[WIDTH-1] when MSB_FIRST=1, else D[0].
REQ-020 A LOAD with LEN=0 SHALL remain in (or return to) IDLE, with Q=IDLE_LEVEL, and SHALL pulse DONE for one cycle after the edge.
REQ-021 In SHIFT, SHIFT_EN=1 with LOAD=0 SHALL perform one shift step per edge:
  - shift the register one position toward the output end, inserting FILL_BIT at the opposite end;
  - decrement REMAIN;
  - update Q to the new output-end bit.
REQ-022 When a SHIFT_EN edge takes REMAIN from 1 to 0, the block SHALL:
  - enter IDLE;
  - set Q=IDLE_LEVEL;
  - pulse DONE high for exactly the following cycle.
REQ-023 SHIFT_EN=0 SHALL hold all state; SHIFT_EN in IDLE SHALL be ignored.
REQ-024 LOAD SHALL take priority over SHIFT_EN on the same edge.
REQ-025 DONE SHALL never be high for two consecutive cycles unless consecutive completions occur (e.g. repeated LEN=0 loads).
REQ-026 PAR_Q SHALL reflect register contents at all times, including after completion (contents then hold, shifted by LEN positions).
REQ-027 LEN values greater than WIDTH SHALL be clamped to WIDTH; there is no wrap-around of REMAIN.

Reset
REQ-028 RST_N=0 at a rising edge SHALL set, regardless of LOAD or SHIFT_EN:
  - state IDLE;
  - shift register to all zeros, so PAR_Q=0;
  - REMAIN=0, BUSY=0, DONE=0;
  - Q=IDLE_LEVEL.
REQ-029 A reset asserted mid-emission SHALL abort the emission without a DONE pulse; outputs are undefined only before the first reset edge.

Verification
REQ-030 The bench SHALL cover each of the following directed scenarios (defaults WIDTH=8, MSB_FIRST=1, IDLE_LEVEL=0, FILL_BIT=0):
  - Basic emission: LOAD D=8'b1011_0000, LEN=4, then SHIFT_EN held high -> Q sequence 1,0,1,1; REMAIN counts 4,3,2,1; DONE pulses once; then Q=0 and BUSY=0.
  - LSB-first: MSB_FIRST=0, D=8'h0D, LEN=4 -> Q sequence 1,0,1,1; PAR_Q=8'h00 after completion.
  - Restart: LOAD new D=8'hFF, LEN=2 at the 2nd shift of an LEN=5 emission -> no DONE for the first emission; Q=1,1 follows; one DONE.
  - LEN=0 and clamping: LEN=0 -> BUSY stays 0, one DONE pulse; LEN=12 with WIDTH=8 -> REMAIN=8 and exactly 8 bits emitted.
  - Gapped strobe and reset: SHIFT_EN pulsed every 3rd cycle -> Q holds between strobes; RST_N=0 mid-emission -> next cycle BUSY=0, REMAIN=0, PAR_Q=0, Q=0, no DONE.
